pkt_reader: RTL
===============

Name: pkt_reader

Overview:
- Downstream consumer of the 8x32 dual-port packet RAM stage; runs in the 100 MHz PLL clock domain.
- On each new package_full indication it reads all DEPTH bytes from the RAM read port in order, from address 0 upward.
- It streams the bytes out over a valid/ready byte interface and appends a two's-complement checksum byte.
- It reports busy, done and overrun status to the controlling logic.

Parameters:
- DEPTH, 32, packet length in bytes; equals the RAM depth.
- AW, 5, RAM address width; DEPTH = 2**AW.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in clocks from the rd_en cycle to valid rd_data; legal range 1..3.
- ADD_CSUM, 1, 1 appends a checksum byte after the data, 0 sends data only.

Ports:
- clk  in  1  system clock, 100 MHz PLL output
- rst  in  1  reset, asynchronous, active-low
- package_full  in  1  RAM-full flag from the write side; level, edge-detected internally
- rd_en  out  1  RAM read enable
- rd_addr  out  AW  RAM read address
- rd_data  in  DW  RAM read data (RAM q)
- out_data  out  DW  streamed byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the byte
- out_last  out  1  marks the final byte of the packet
- busy  out  1  packet transfer in progress
- done  out  1  one-cycle pulse at the end of a packet
- overrun  out  1  sticky; a new packet was flagged while busy

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst). While rst=0:
  - state=IDLE; rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, overrun=0.
  - Byte index=0, checksum accumulator=0, pf_d=0.
- Reset mid-packet aborts the transfer immediately. No done pulse is produced, and no partial state survives reset.
- Edge detect: pf_d is package_full registered. start = package_full & ~pf_d. If package_full is already high on the first clock after reset, that counts as a start.
- States: IDLE, READ, WAIT, SEND, CSUM.
- IDLE: on start, go to READ with idx=0 and sum=0.
- READ, one cycle only:
  - Drive rd_en=1 and rd_addr=idx.
  - Go to WAIT and load the wait counter with RD_LAT.
- WAIT:
  - rd_en=0 and rd_addr holds its value.
  - Decrement the counter each cycle. On the cycle where rd_data is valid (RD_LAT cycles after the READ cycle), register rd_data into out_data and go to SEND.
  - out_valid rises exactly RD_LAT+1 cycles after the READ cycle.
- SEND:
  - out_valid=1. out_data and out_last stay stable until a transfer occurs.
  - Transfer happens on a rising edge where out_valid&out_ready=1.
  - On transfer: sum <= sum + out_data (mod 2**DW).
  - If idx<DEPTH-1: idx++, go to READ.
  - Otherwise: go to CSUM if ADD_CSUM=1, else go to IDLE.
  - out_ready may be low for any number of cycles; the block holds with no data loss.
- CSUM:
  - out_data = (~sum)+1 (mod 2**DW), out_valid=1, out_last=1.
  - On transfer, go to IDLE.
  - Sum of all DEPTH+1 transmitted bytes = 0 mod 256.
- out_last:
  - ADD_CSUM=1: high only with the checksum byte.
  - ADD_CSUM=0: high only with data byte DEPTH-1.
- done: a one-cycle pulse in the cycle after the final transfer, coinciding with the return to IDLE.
- busy = (state != IDLE).
- Minimum rate is one byte per RD_LAT+2 cycles. No read is issued until the previous byte has been accepted, so there is no internal buffering.
- Overrun:
  - A start seen while busy=1 sets overrun=1 and is otherwise ignored; the current packet continues unaffected.
  - overrun is cleared only by reset.
  - A start in the same cycle that done is asserted (state already IDLE) is accepted normally.
- Wrap: idx is AW bits wide. Terminal detection is idx==DEPTH-1; rd_addr never wraps within a packet.

Test Plan:
- Reset, then write RAM bytes 0x01..0x20 and raise package_full, out_ready=1:
  - 33 bytes 0x01..0x20 then 0xF0 (sum 0x210, low byte 0x10, negated 0xF0).
  - out_last only on 0xF0; done pulses once; busy falls with done.
- Same data with out_ready toggling 1,0,0,1 (pattern repeated):
  - Identical byte sequence; out_data stable while out_valid&~out_ready; no duplicated or skipped bytes.
- RD_LAT=2, RAM filled with 0xFF:
  - rd_en pulse to out_valid rise is 3 cycles.
  - 32x 0xFF then 0x20; rd_addr steps 0..31.
- A second package_full rising edge during byte 10, ADD_CSUM=0:
  - overrun=1 and stays high.
  - Packet completes with 32 bytes; out_last on byte 31; no restart afterwards.
- Assert rst=0 during byte 15:
  - All outputs return to 0 asynchronously; no done pulse.
  - After release, a new package_full rising edge produces a full 33-byte packet starting at address 0.

Source files
------------

// File: rtl/pkt_reader_if.sv
// Byte stream carrying packet data and checksum
// out of the packet RAM reader.
interface pkt_reader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pkt_reader.sv
// Reads a full packet from the dual-port RAM and
// streams it out, optionally with a checksum byte.
module pkt_reader #(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int ADD_CSUM = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          package_full,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  pkt_reader_if.master  stream,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    CSUM
  } state_t;

  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [1:0]    LAT   = 2'(RD_LAT);
  localparam logic [1:0]    C_ONE = 2'd1;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          pf_q;
  logic          start;
  logic          xfer;
  logic [DW-1:0] nsum;

  assign start = package_full & ~pf_q;
  assign xfer  = stream.out_valid & stream.out_ready;
  assign nsum  = sum_q + data_q;

  assign rd_en   = (state_q == READ);
  assign rd_addr = idx_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = ovr_q;

  assign stream.out_data  = data_q;
  assign stream.out_valid = (state_q == SEND) ||
                            (state_q == CSUM);
  assign stream.out_last  = (state_q == CSUM) ||
                            ((ADD_CSUM == 0) &&
                             (state_q == SEND) &&
                             (idx_q == LAST));

  // next-state: read one byte, wait, hand off, repeat
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (start && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = LAT;
      end
      WAIT: begin
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          data_d  = rd_data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          sum_d = nsum;
          if (idx_q != LAST) begin
            idx_d   = idx_q + A_ONE;
            state_d = READ;
          end else if (ADD_CSUM != 0) begin
            data_d  = ~nsum + D_ONE;
            state_d = CSUM;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      pf_q    <= package_full;
    end
  end

endmodule
